seg_scan_ctrl: RTL and testbench
================================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter NUM_DIGITS, default 6: number of multiplexed digits; legal range 2..8.
REQ-002 Parameter ON_CYCLES, default 40000: clock cycles each digit is driven; minimum 1.
REQ-003 Parameter BLANK_CYCLES, default 2000: anti-ghost gap after each digit, all enables off; minimum 1.
REQ-004 clk  in  1  single clock, rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 en  in  1  scan enable; 0 forces idle.
REQ-007 upd_valid  in  1  new display contents offered.
REQ-008 upd_data  in  4*NUM_DIGITS  BCD digits; digit 0 in bits [3:0]; digit NUM_DIGITS-1 is the most significant and leftmost.
REQ-009 upd_ready  out  1  shadow register accepts upd_data this cycle.
REQ-010 dig_en  out  NUM_DIGITS  one-hot digit enable, active-high; all-zero when blanking or idle.
REQ-011 seg  out  7  active-high segment pattern, bit 6 = a, bit 0 = g.
REQ-012 frame_done  out  1  one-cycle pulse at the end of a full scan.

Function
REQ-013 States: IDLE, SCAN, BLANK; state, digit index idx, cycle counter cnt, dig_en, frame_done and the internal 4-bit code are registered.
REQ-014 IDLE -> SCAN (idx=0, cnt=0) on the first clock edge with en=1.
REQ-015 SCAN: dig_en = one-hot(idx); code = shadow digit idx; cnt counts 0..ON_CYCLES-1, then BLANK with cnt=0.
REQ-016 BLANK: dig_en = 0, code = 4'hF; cnt counts 0..BLANK_CYCLES-1, then SCAN with idx+1.
REQ-017 Wrap: at the end of BLANK for idx=NUM_DIGITS-1, idx returns to 0 and frame_done is 1 for exactly that one cycle.
REQ-018 Frame period SHALL be exactly NUM_DIGITS*(ON_CYCLES+BLANK_CYCLES) cycles.
REQ-019 seg SHALL be the combinational decode of the registered code: codes 0-9 give standard glyphs, including 8 = 7'b1111111; codes 10-15 give 7'b0000000.
REQ-020 upd_ready = 1 in IDLE, and in BLANK while idx=NUM_DIGITS-1; otherwise 0.
REQ-021 On upd_valid && upd_ready, the shadow register takes upd_data at that edge, so digits never change mid-frame; upd_valid without upd_ready is ignored, with no stall of the scan.
REQ-022 en falling in any state: next edge enters IDLE with dig_en=0, code=4'hF, idx=0, cnt=0; no frame_done pulse.
REQ-023 en rising again: scan restarts at digit 0 per REQ-014.
REQ-024 Shadow BCD values 10-15 display blank; no error is flagged.

Reset
REQ-025 rst=1 SHALL asynchronously force: state=IDLE, idx=0, cnt=0, dig_en=0, code=4'hF (seg=0), frame_done=0, shadow=0.
REQ-026 upd_ready reads 1 during reset; a reset mid-SCAN SHALL blank dig_en in the same cycle, without waiting for a clock edge.

Configuration
REQ-027 Macro SEG_SCAN_LZ_BLANK_EN: when defined, leading-zero suppression applies from digit NUM_DIGITS-1 downward. Each digit is shown as code 4'hF while it and all more significant digits are 0. Digit 0 is never suppressed.
REQ-028 Without SEG_SCAN_LZ_BLANK_EN, all digits display literally and no suppression logic is present.

Structure
REQ-029 A shared package seg_pkg SHALL hold: the state enum, the blank code constant 4'hF, the segment bit-order constants and the glyph table.
REQ-030 One sub-module, seg_decode (4-bit code in, 7-bit seg out, purely combinational), SHALL be instantiated once and shared by all digits.

Verification (NUM_DIGITS=4, ON_CYCLES=3, BLANK_CYCLES=1)
REQ-031 Reset, en=1, load 16'h1234 in IDLE -> dig_en 0001 with seg(4) for 3 cycles, 0000 for 1 cycle, then 0010 with seg(3); frame_done pulses every 16 cycles.
REQ-032 upd_valid with 16'h5678 mid-frame -> upd_ready=0, display unchanged; held valid until the last BLANK -> accepted, next frame shows 5678.
REQ-033 en dropped during SCAN of digit 2 -> next cycle dig_en=0000 and seg=0; en restored -> scan resumes at digit 0 after 1 cycle.
REQ-034 rst asserted mid-SCAN between edges -> dig_en=0000 immediately; after release all outputs hold reset values until en is seen.
REQ-035 With SEG_SCAN_LZ_BLANK_EN, data 16'h0005 -> digits 3..1 seg=0, digit 0 shows 5; data 16'h0000 -> only digit 0 shows 0.
REQ-036 Shadow 16'hA080 -> digit 3 blank, digit 1 shows 7'b1111111, digits 2 and 0 show 0.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed 7-segment scanner:
// scan states, blank code, segment bit order and the BCD glyph table.
package seg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_BLANK = 2'd2
    } scan_state_t;

    localparam logic [3:0] BLANK_CODE = 4'hF;

    // Segment bit positions within the 7-bit pattern (a is the MSB).
    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    // Entry n is the glyph for BCD digit n, pattern order a..g.
    localparam logic [9:0][6:0] GLYPH_TABLE = {
        7'b1111011,  // 9
        7'b1111111,  // 8
        7'b1110000,  // 7
        7'b1011111,  // 6
        7'b1011011,  // 5
        7'b0110011,  // 4
        7'b1111001,  // 3
        7'b1101101,  // 2
        7'b0110000,  // 1
        7'b1111110   // 0
    };

    function automatic logic [6:0] glyph(input logic [3:0] code);
        logic [6:0] pattern;
        pattern = 7'b0000000;
        if (code <= 4'd9) begin
            pattern = GLYPH_TABLE[code];
        end
        return pattern;
    endfunction

endpackage

// File: rtl/seg_decode.sv
// Purely combinational BCD-to-7-segment decoder; codes 10-15 (including
// the blank code) turn every segment off.
module seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] i_code,
    output logic [6:0] o_seg
);

    assign o_seg = glyph(i_code);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller with a frame-synchronous shadow
// register. Optional leading-zero suppression: define SEG_SCAN_LZ_BLANK_EN.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 6,
    parameter int ON_CYCLES    = 40000,
    parameter int BLANK_CYCLES = 2000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      upd_valid,
    input  logic [4*NUM_DIGITS-1:0]   upd_data,
    output logic                      upd_ready,
    output logic [NUM_DIGITS-1:0]     dig_en,
    output logic [6:0]                seg,
    output logic                      frame_done
);

    localparam int CNT_MAX = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IDX_W   = $clog2(NUM_DIGITS);

    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0]      ON_LAST  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0]      BL_LAST  = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [NUM_DIGITS-1:0] DIG_ONE  = NUM_DIGITS'(1);

    scan_state_t             r_state;
    logic [IDX_W-1:0]        r_idx;
    logic [CNT_W-1:0]        r_cnt;
    logic [NUM_DIGITS-1:0]   r_dig_en;
    logic [3:0]              r_code;
    logic                    r_frame_done;
    logic [4*NUM_DIGITS-1:0] r_shadow;

    scan_state_t             w_state_next;
    logic [IDX_W-1:0]        w_idx_next;
    logic [CNT_W-1:0]        w_cnt_next;
    logic [NUM_DIGITS-1:0]   w_dig_en_next;
    logic [3:0]              w_code_next;
    logic                    w_frame_done_next;
    logic                    w_accept;
    logic [4*NUM_DIGITS-1:0] w_shadow_next;
    logic [3:0]              w_digit     [NUM_DIGITS];
    logic [3:0]              w_disp_code [NUM_DIGITS];

    assign upd_ready  = (r_state == ST_IDLE) ||
                        ((r_state == ST_BLANK) && (r_idx == LAST_IDX));
    assign w_accept   = upd_valid && upd_ready;

    // Digit codes come from the value the shadow holds after this edge, so a
    // frame that starts on the accepting edge already shows the new contents.
    assign w_shadow_next = w_accept ? upd_data : r_shadow;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign w_digit[gi] = w_shadow_next[gi*4 +: 4];
        end
    endgenerate

`ifdef SEG_SCAN_LZ_BLANK_EN
    // Walk from the leftmost digit down; a digit is suppressed while it and
    // everything to its left is zero. Digit 0 always shows.
    always_comb begin
        logic zero_run;
        zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (w_digit[i] == 4'd0);
            w_disp_code[i] = (i != 0 && zero_run) ? BLANK_CODE : w_digit[i];
        end
    end
`else
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_literal
            assign w_disp_code[gi] = w_digit[gi];
        end
    endgenerate
`endif

    always_comb begin
        w_state_next      = r_state;
        w_idx_next        = r_idx;
        w_cnt_next        = r_cnt;
        w_dig_en_next     = r_dig_en;
        w_code_next       = r_code;
        w_frame_done_next = 1'b0;

        if (!en) begin
            w_state_next  = ST_IDLE;
            w_idx_next    = '0;
            w_cnt_next    = '0;
            w_dig_en_next = '0;
            w_code_next   = BLANK_CODE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_next  = ST_SCAN;
                    w_idx_next    = '0;
                    w_cnt_next    = '0;
                    w_dig_en_next = DIG_ONE;
                    w_code_next   = w_disp_code[0];
                end
                ST_SCAN: begin
                    if (r_cnt == ON_LAST) begin
                        w_state_next  = ST_BLANK;
                        w_cnt_next    = '0;
                        w_dig_en_next = '0;
                        w_code_next   = BLANK_CODE;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
                ST_BLANK: begin
                    if (r_cnt == BL_LAST) begin
                        w_state_next = ST_SCAN;
                        w_cnt_next   = '0;
                        if (r_idx == LAST_IDX) begin
                            w_idx_next        = '0;
                            w_frame_done_next = 1'b1;
                        end else begin
                            w_idx_next = r_idx + 1'b1;
                        end
                        w_dig_en_next = DIG_ONE << w_idx_next;
                        w_code_next   = w_disp_code[w_idx_next];
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_next  = ST_IDLE;
                    w_idx_next    = '0;
                    w_cnt_next    = '0;
                    w_dig_en_next = '0;
                    w_code_next   = BLANK_CODE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_dig_en     <= '0;
            r_code       <= BLANK_CODE;
            r_frame_done <= 1'b0;
            r_shadow     <= '0;
        end else begin
            r_state      <= w_state_next;
            r_idx        <= w_idx_next;
            r_cnt        <= w_cnt_next;
            r_dig_en     <= w_dig_en_next;
            r_code       <= w_code_next;
            r_frame_done <= w_frame_done_next;
            r_shadow     <= w_shadow_next;
        end
    end

    assign dig_en     = r_dig_en;
    assign frame_done = r_frame_done;

    seg_decode u_decode (
        .i_code (r_code),
        .o_seg  (seg)
    );

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed self-checking bench for seg_scan_ctrl with 4 digits,
// 3 on-cycles and 1 blank cycle per digit (16-cycle frame).
module tb_seg_scan_ctrl;

    localparam logic [6:0] G0 = 7'b1111110;
    localparam logic [6:0] G3 = 7'b1111001;
    localparam logic [6:0] G5 = 7'b1011011;
    localparam logic [6:0] G6 = 7'b1011111;
    localparam logic [6:0] G8 = 7'b1111111;
    localparam logic [6:0] G1 = 7'b0110000;
    localparam logic [6:0] G2 = 7'b1101101;
    localparam logic [6:0] G4 = 7'b0110011;
    localparam logic [6:0] G7 = 7'b1110000;
    localparam logic [6:0] OFF = 7'b0000000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        upd_valid = 1'b0;
    logic [15:0] upd_data = 16'h0000;
    logic        upd_ready;
    logic [3:0]  dig_en;
    logic [6:0]  seg;
    logic        frame_done;

    int checks = 0;
    int failures = 0;

    seg_scan_ctrl #(
        .NUM_DIGITS   (4),
        .ON_CYCLES    (3),
        .BLANK_CYCLES (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .upd_valid  (upd_valid),
        .upd_data   (upd_data),
        .upd_ready  (upd_ready),
        .dig_en     (dig_en),
        .seg        (seg),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".dig_en"}, 16'(dig_en), 16'h0);
        chk({tag, ".seg"}, 16'(seg), 16'(OFF));
        chk({tag, ".ready"}, 16'(upd_ready), 16'h1);
        chk({tag, ".fdone"}, 16'(frame_done), 16'h0);
    endtask

    // Checks one full frame starting at digit 0, first on-cycle, then
    // advances to the first cycle of the following frame.
    task automatic frame(input string tag, input logic fd0,
                         input logic [6:0] s0, input logic [6:0] s1,
                         input logic [6:0] s2, input logic [6:0] s3);
        logic [6:0] segs [4];
        segs[0] = s0; segs[1] = s1; segs[2] = s2; segs[3] = s3;
        for (int k = 0; k < 16; k++) begin
            int d;
            int ph;
            logic [3:0] e_dig;
            logic [6:0] e_seg;
            string t;
            d = k / 4;
            ph = k % 4;
            e_dig = (ph < 3) ? (4'b0001 << d) : 4'b0000;
            e_seg = (ph < 3) ? segs[d] : OFF;
            t = $sformatf("%s.k%0d", tag, k);
            $display("TB txn %s dig_en=%b seg=%b ready=%b fdone=%b",
                     t, dig_en, seg, upd_ready, frame_done);
            chk({t, ".dig_en"}, 16'(dig_en), 16'(e_dig));
            chk({t, ".seg"}, 16'(seg), 16'(e_seg));
            chk({t, ".ready"}, 16'(upd_ready), (k == 15) ? 16'h1 : 16'h0);
            chk({t, ".fdone"}, 16'(frame_done), (k == 0 && fd0) ? 16'h1 : 16'h0);
            step();
        end
    endtask

    initial begin
        // Reset state, checked while reset is held and after release.
        #2 rst = 1'b1;
        #1 chk_idle("rst_async");
        step();
        step();
        chk_idle("rst_held");
        rst = 1'b0;
        step();
        step();
        chk_idle("idle_after_rst");

        // Load 1234 in IDLE on the same edge the scan starts.
        en = 1'b1;
        upd_valid = 1'b1;
        upd_data = 16'h1234;
        step();
        upd_valid = 1'b0;
        frame("f1234", 1'b0, G4, G3, G2, G1);

        // Offer 5678 mid-frame: held off until the last blank, then shown.
        upd_valid = 1'b1;
        upd_data = 16'h5678;
        frame("f1234_hold", 1'b1, G4, G3, G2, G1);
        upd_valid = 1'b0;
        frame("f5678", 1'b1, G8, G7, G6, G5);

        // Drop en during the scan of digit 2.
        for (int i = 0; i < 8; i++) step();
        chk("en_drop.pre_dig", 16'(dig_en), 16'h4);
        chk("en_drop.pre_seg", 16'(seg), 16'(G6));
        en = 1'b0;
        step();
        chk_idle("en_drop");
        en = 1'b1;
        step();
        frame("resume", 1'b0, G8, G7, G6, G5);

        // Asynchronous reset between edges while scanning digit 0.
        chk("pre_rst.fdone", 16'(frame_done), 16'h1);
        chk("pre_rst.dig", 16'(dig_en), 16'h1);
        #3 rst = 1'b1;
        #1 chk_idle("rst_mid");
        step();
        en = 1'b0;
        rst = 1'b0;
        step();
        step();
        chk_idle("post_rst");
        en = 1'b1;
        step();
`ifdef SEG_SCAN_LZ_BLANK_EN
        frame("shadow0", 1'b0, G0, OFF, OFF, OFF);
`else
        frame("shadow0", 1'b0, G0, G0, G0, G0);
`endif

        // 0005, loaded while idle.
        en = 1'b0;
        step();
        upd_valid = 1'b1;
        upd_data = 16'h0005;
        step();
        upd_valid = 1'b0;
        chk_idle("load0005");
        en = 1'b1;
        step();
`ifdef SEG_SCAN_LZ_BLANK_EN
        frame("d0005", 1'b0, G5, OFF, OFF, OFF);
`else
        frame("d0005", 1'b0, G5, G0, G0, G0);
`endif

        // 0000, loaded on the edge that restarts the scan.
        en = 1'b0;
        step();
        en = 1'b1;
        upd_valid = 1'b1;
        upd_data = 16'h0000;
        step();
        upd_valid = 1'b0;
`ifdef SEG_SCAN_LZ_BLANK_EN
        frame("d0000", 1'b0, G0, OFF, OFF, OFF);
`else
        frame("d0000", 1'b0, G0, G0, G0, G0);
`endif

        // A080: non-BCD leftmost digit shows blank; no suppression applies.
        en = 1'b0;
        step();
        upd_valid = 1'b1;
        upd_data = 16'hA080;
        step();
        upd_valid = 1'b0;
        en = 1'b1;
        step();
        frame("dA080", 1'b0, G0, G8, G0, OFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
